// File: rtl/io_mmio_if.sv
// Data-side MMIO bus and UART ready/valid lines between the core and io_mmio.
// The slave modport is the io_mmio view; master is the core/UART side.
interface io_mmio_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        inst_retire;
    logic [31:0] rdata;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;

    modport slave (
        input  addr, wdata, we, re, inst_retire,
        input  uart_rx_data, uart_rx_valid, uart_tx_ready,
        output rdata, uart_rx_ready, uart_tx_data, uart_tx_valid
    );

    modport master (
        output addr, wdata, we, re, inst_retire,
        output uart_rx_data, uart_rx_valid, uart_tx_ready,
        input  rdata, uart_rx_ready, uart_tx_data, uart_tx_valid
    );
endinterface

// File: rtl/io_mmio.sv
// MMIO controller for the 0x8000_0000 region: UART bridge plus cycle and
// retired-instruction counters, with load data registered like dmem output.
module io_mmio (
    input  logic     clk,
    input  logic     rst,
    io_mmio_if.slave bus
);
    // Word addresses (byte address >> 2); addr[1:0] never takes part in decode.
    localparam logic [29:0] WA_UART_CTRL = 30'h2000_0000;
    localparam logic [29:0] WA_UART_RX   = 30'h2000_0001;
    localparam logic [29:0] WA_UART_TX   = 30'h2000_0002;
    localparam logic [29:0] WA_CYCLE     = 30'h2000_0004;
    localparam logic [29:0] WA_INST      = 30'h2000_0005;
    localparam logic [29:0] WA_CNT_CLR   = 30'h2000_0006;

    logic [29:0] word;
    logic [31:0] rd_mux;
    logic        tx_fire;
    logic        cnt_clr;

    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] inst_q, inst_d;

    // Byte lanes and sub-word offsets are resolved in write-back, not here.
    logic unused_bits;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:8]};

    assign word              = bus.addr[31:2];
    assign bus.uart_rx_ready = bus.re && (word == WA_UART_RX);
    assign bus.rdata         = rdata_q;
    assign bus.uart_tx_data  = tx_data_q;
    assign bus.uart_tx_valid = tx_valid_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        rd_mux = '0;
        case (word)
            WA_UART_CTRL: rd_mux = {30'b0, bus.uart_rx_valid, bus.uart_tx_ready};
            WA_UART_RX:   rd_mux = {24'b0, bus.uart_rx_data};
            WA_CYCLE:     rd_mux = cycle_q;
            WA_INST:      rd_mux = inst_q;
            default:      rd_mux = '0;
        endcase

        tx_fire = bus.we && (word == WA_UART_TX) && bus.uart_tx_ready;
        cnt_clr = bus.we && (word == WA_CNT_CLR);

        rdata_d    = bus.re ? rd_mux : rdata_q;
        tx_valid_d = tx_fire;
        tx_data_d  = tx_fire ? bus.wdata[7:0] : tx_data_q;

        // A clear store wins over the same cycle's increment and retire pulse.
        cycle_d = cnt_clr ? '0 : cycle_q + 32'd1;
        inst_d  = cnt_clr ? '0 : inst_q + {31'b0, bus.inst_retire};
    end

    // NOTE: state registers use non-blocking assignments; rst is synchronous, so it sits inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            cycle_q    <= '0;
            inst_q     <= '0;
        end else begin
            rdata_q    <= rdata_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cycle_q    <= cycle_d;
            inst_q     <= inst_d;
        end
    end
endmodule
